bf16_op_issuer: RTL
===================

BF16_OP_ISSUER -- requirements
Module: bf16_op_issuer

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3 (legal 1..15), giving the cycles from au_* operands presented to au_result valid.
REQ-002 The block SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  issuer accepts a request.
- req_op  in  3  0 ADD, 1 SUB, 2 MUL, 3 FMADD, 4 FMSUB, 5-7 illegal.
- req_a, req_b, req_c  in  16 each  BF16 operands.
- au_valid  out  1  operation in flight in the arithmetic unit.
- au_funct5  out  5  operation code to the arithmetic unit's operand decoder.
- au_in1, au_in2, au_in3  out  16 each  raw operands a, b, c.
- au_result  in  16  BF16 result from the arithmetic unit.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  16  captured result.
- rsp_err  out  1  illegal op.
- busy  out  1  state != IDLE.
REQ-003 The block SHALL use one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, EXEC and RESP; all outputs SHALL be registered or decoded from state only.
REQ-005 req_ready SHALL be 1 only in IDLE; acceptance SHALL be req_valid && req_ready at a rising edge; req_valid outside IDLE SHALL be ignored.
REQ-006 On accepting a legal op, the block SHALL go to EXEC and, from the next cycle, drive au_valid=1 and au_in1/2/3 = req_a/b/c.
REQ-007 On accepting a legal op, au_funct5 SHALL be ADD 00000, SUB 00001, MUL 00010, FMADD 00100, FMSUB 00101.
REQ-008 au_* outputs SHALL be held stable for all of EXEC.
REQ-009 A 4-bit down-counter SHALL be loaded with LATENCY-1 on acceptance and SHALL decrement each EXEC cycle.
REQ-010 In the EXEC cycle with counter == 0 (the LATENCY-th EXEC cycle), au_result SHALL be captured into rsp_data, rsp_err SHALL be set to 0, and the FSM SHALL go to RESP.
REQ-011 rsp_valid SHALL rise exactly LATENCY+1 cycles after the acceptance edge.
REQ-012 On leaving EXEC: au_valid=0, au_funct5=11111 (decoder default, zero operands), au_in1/2/3=0.
REQ-013 An illegal op (5-7) SHALL skip EXEC and go directly to RESP.
REQ-014 For an illegal op, rsp_data=0 and rsp_err=1, with rsp_valid high the cycle after acceptance.
REQ-015 For an illegal op, au_valid SHALL stay 0 and au_funct5 SHALL stay 11111.
REQ-016 In RESP, rsp_valid=1 and rsp_data and rsp_err SHALL be held until rsp_valid && rsp_ready.
REQ-017 On the response handshake the FSM SHALL go to IDLE; req_ready SHALL be 1 the following cycle, with no same-cycle turnaround.
REQ-018 Throughput SHALL be one transaction outstanding; back-to-back issue period SHALL be LATENCY+2 cycles minimum for a legal op with rsp_ready held high.
REQ-019 busy SHALL equal (state != IDLE).

Reset
REQ-020 rsp_valid, rsp_data, rsp_err, au_valid, au_in1/2/3 and the counter SHALL reset to 0.
REQ-021 At reset, state SHALL be IDLE, req_ready=1, busy=0 and au_funct5=11111.
REQ-022 Reset asserted mid-EXEC or mid-RESP SHALL discard the transaction immediately; no response SHALL be produced after release.

Verification
REQ-023 Reset: rst_n low with random inputs -> req_ready=1, rsp_valid=0, au_valid=0, au_funct5=11111; outputs unchanged after release with req_valid=0.
REQ-024 ADD, LATENCY=3: op=0, a=3F80, b=4000 accepted at edge T -> T+1..T+3: au_valid=1, funct5=00000, in1=3F80, in2=4000; model drives au_result=4040 -> rsp_valid at T+4, rsp_data=4040, rsp_err=0.
REQ-025 FMADD: op=3, a=4000, b=4000, c=3F80 -> funct5=00100, in3=3F80, rsp_data equals model value; FMSUB op=4 -> funct5=00101.
REQ-026 Illegal: op=6 -> rsp_valid at T+1, rsp_err=1, rsp_data=0000, au_valid never 1, au_funct5=11111 throughout.
REQ-027 Backpressure: rsp_ready low 5 cycles while new req_valid toggles -> rsp_* held, req_ready=0, no extra acceptance; after handshake, req_ready=1 the next cycle.
REQ-028 Reset mid-EXEC: rst_n pulsed low at T+2 of a MUL -> immediate IDLE, au_valid=0, no rsp_valid afterwards.

Source files
------------

// File: rtl/bf16_op_issuer.sv
// Issues one BF16 operation at a time to a fixed-latency arithmetic unit and
// returns its result (or an illegal-op error) through a valid/ready response port.
module bf16_op_issuer #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [15:0] req_c,
  output logic        au_valid,
  output logic [4:0]  au_funct5,
  output logic [15:0] au_in1,
  output logic [15:0] au_in2,
  output logic [15:0] au_in3,
  input  logic [15:0] au_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Decoder default: the arithmetic unit treats this as zero operands.
  localparam logic [4:0] FUNCT5_NONE = 5'b11111;
  localparam logic [3:0] CNT_LOAD    = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;

  function automatic logic [4:0] op_funct5(input logic [2:0] op);
    case (op)
      3'd0:    return 5'b00000;
      3'd1:    return 5'b00001;
      3'd2:    return 5'b00010;
      3'd3:    return 5'b00100;
      3'd4:    return 5'b00101;
      default: return FUNCT5_NONE;
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // NOTE: every register below uses <= so all state updates see the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      au_valid  <= 1'b0;
      au_funct5 <= FUNCT5_NONE;
      au_in1    <= '0;
      au_in2    <= '0;
      au_in3    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_op <= 3'd4) begin
              state     <= EXEC;
              cnt       <= CNT_LOAD;
              au_valid  <= 1'b1;
              au_funct5 <= op_funct5(req_op);
              au_in1    <= req_a;
              au_in2    <= req_b;
              au_in3    <= req_c;
            end else begin
              // Illegal op never touches the arithmetic unit.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end

        EXEC: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= au_result;
            rsp_err   <= 1'b0;
            au_valid  <= 1'b0;
            au_funct5 <= FUNCT5_NONE;
            au_in1    <= '0;
            au_in2    <= '0;
            au_in3    <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
